st_dat_rmw: RTL

//  Store-side partner to the load-data extender: takes sb/sh/sw requests from the MEM stage
//  and writes them to a word-only data memory (no byte strobes).
//  sw goes straight to a word write; sb/sh do read-modify-write: read word, merge lane, write back.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/st_dat_rmw_if.sv | 55 +++++
 rtl/st_dat_merge.sv | 26 ++
 rtl/st_dat_rmw.sv | 98 +++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared types: store one-hot codes, store FSM states,
// and the store legality check used at request accept.
package lsu_pkg;

    localparam logic [2:0] ST_SB = 3'b100;
    localparam logic [2:0] ST_SH = 3'b010;
    localparam logic [2:0] ST_SW = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR
    } st_state_t;

    // Type must be exactly one-hot; sh needs halfword and
    // sw needs word alignment.
    function automatic logic st_legal(
        input logic [2:0] src,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b0;
        case (src)
            ST_SB:   ok = 1'b1;
            ST_SH:   ok = ~off[0];
            ST_SW:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/st_dat_rmw_if.sv
// Store request/response and word-memory bus bundle for st_dat_rmw.
// slave: the store block; master: MEM stage plus the memory.
interface st_dat_rmw_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        StoreSrcM;
    logic [ADDR_W-1:0] AddrM;
    logic [31:0]       WriteDataM;
    logic              st_done;
    logic              st_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              mem_wack;

    modport slave (
        input  req_valid,
        output req_ready,
        input  StoreSrcM,
        input  AddrM,
        input  WriteDataM,
        output st_done,
        output st_err,
        output mem_addr,
        output mem_re,
        input  mem_rvalid,
        input  mem_rdata,
        output mem_we,
        output mem_wdata,
        input  mem_wack
    );

    modport master (
        output req_valid,
        input  req_ready,
        output StoreSrcM,
        output AddrM,
        output WriteDataM,
        input  st_done,
        input  st_err,
        input  mem_addr,
        input  mem_re,
        output mem_rvalid,
        output mem_rdata,
        input  mem_we,
        input  mem_wdata,
        output mem_wack
    );

endinterface

// File: rtl/st_dat_merge.sv
// Combinational lane merge: old word + store data/type/offset -> new word.
// Ports: old_word, data, src (one-hot sb/sh/sw), off (byte offset), merged.
module st_dat_merge
    import lsu_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [2:0]  src,
    input  logic [1:0]  off,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        unique case (1'b1)
            src[2]: merged[{off, 3'b000} +: 8] = data[7:0];
            src[1]: begin
                if (off[1]) merged[31:16] = data[15:0];
                else        merged[15:0]  = data[15:0];
            end
            src[0]: merged = data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/st_dat_rmw.sv
// Store unit: sw written directly, sb/sh via read-modify-write on a
// word-only memory; illegal requests rejected with st_err.
// Ports: clk, rst (async high), bus (slave: request, done/err, mem bus).
module st_dat_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter bit SW_BYPASS = 1'b1
) (
    input logic         clk,
    input logic         rst,
    st_dat_rmw_if.slave bus
);

    st_state_t   state;
    logic [2:0]  cap_src;
    logic [1:0]  cap_off;
    logic [31:0] cap_data;
    logic [31:0] merged;
    logic        legal;
    logic        direct_sw;
    logic [ADDR_W-1:0] word_addr;

    assign legal = st_legal(bus.StoreSrcM, bus.AddrM[1:0]);
    assign direct_sw = SW_BYPASS && (bus.StoreSrcM == ST_SW);
    assign word_addr = {bus.AddrM[ADDR_W-1:2], 2'b00};

    st_dat_merge u_merge (
        .old_word (bus.mem_rdata),
        .data     (cap_data),
        .src      (cap_src),
        .off      (cap_off),
        .merged   (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cap_src       <= ST_SW;
            cap_off       <= 2'b00;
            cap_data      <= 32'h0;
            bus.req_ready <= 1'b1;
            bus.st_done   <= 1'b0;
            bus.st_err    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= 32'h0;
        end else begin
            bus.st_done <= 1'b0;
            bus.st_err  <= 1'b0;
            bus.mem_re  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (!legal) begin
                            bus.st_err <= 1'b1;
                        end else begin
                            cap_src       <= bus.StoreSrcM;
                            cap_off       <= bus.AddrM[1:0];
                            cap_data      <= bus.WriteDataM;
                            bus.mem_addr  <= word_addr;
                            bus.req_ready <= 1'b0;
                            if (direct_sw) begin
                                state         <= WR;
                                bus.mem_we    <= 1'b1;
                                bus.mem_wdata <= bus.WriteDataM;
                            end else begin
                                state      <= RD_REQ;
                                bus.mem_re <= 1'b1;
                            end
                        end
                    end
                end
                RD_REQ, RD_WAIT: begin
                    // RD_REQ also catches a zero-latency read
                    if (bus.mem_rvalid) begin
                        state         <= WR;
                        bus.mem_we    <= 1'b1;
                        bus.mem_wdata <= merged;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                WR: begin
                    if (bus.mem_wack) begin
                        state         <= IDLE;
                        bus.mem_we    <= 1'b0;
                        bus.req_ready <= 1'b1;
                        bus.st_done   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
